sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, show-ahead 32-bit FIFO with a bypass path. It buffers write-side data for a downstream consumer and is the design the team's in-order scoreboard checks. Accept rules are fixed so the scoreboard's valid equations hold exactly:
- write accepted = `write_en && (!full || read_en)`
- read accepted = `read_en && (!empty || write_en)`

## Interface
Parameters:
- `DATA_W`, 32: data width.
- `DEPTH`, 8: number of entries; power of two, at least 2.
- `CNT_W`, $clog2(DEPTH)+1: occupancy width; derived, do not override.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `write_en`  in  1: write request.
- `write_data`  in  DATA_W: write payload.
- `read_en`  in  1: read request.
- `read_data`  out  DATA_W: head data, valid in the same cycle as `read_en`.
- `full`  out  1: count == DEPTH.
- `empty`  out  1: count == 0.
- `count`  out  CNT_W: current occupancy.
- `overflow`  out  1: sticky error flag; see Configuration.
- `underflow`  out  1: sticky error flag; see Configuration.

## Operation
- State: `mem[DEPTH]`, `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits each (wrap naturally), and `count`.
- Write accepted, not bypassed: `mem[wr_ptr] <= write_data`, `wr_ptr` increments.
- Read accepted, not bypassed: `rd_ptr` increments.
- `count` next value:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both, or on neither.
- `read_data`, combinational (show-ahead):
  - `empty && write_en`: `write_data` (bypass).
  - `!empty`: `mem[rd_ptr]`.
  - Otherwise: 0.
- Bypass (`empty`, `write_en`, `read_en` all high): data flows straight through. `mem`, pointers and `count` are untouched and `empty` stays 1.
- Full with simultaneous read and write:
  - Head is read and the new word is written into the freed slot.
  - `count` stays DEPTH and `full` stays 1.
- Full with write only: write dropped, state unchanged.
- Empty with read only: read ignored, `read_data` = 0, state unchanged.
- Only `mem` is left unreset; all other state is cleared by `rst`.

## Timing
- Reset values: `count`=0, `empty`=1, `full`=0, `read_data`=0 (write_en low), `overflow`=0, `underflow`=0, pointers 0.
- `rst` has priority over any same-cycle write or read.
- `rst` mid-operation discards all contents on the next edge. No data are returned afterwards.
- Write-to-read latency:
  - 1 cycle through storage: data written at edge N appears on `read_data` after N.
  - 0 cycles through bypass.
- `full`, `empty` and `count` are derived from registered state. They update one edge after the accepted transfer.
- Throughput: one write and one read per cycle, in every occupancy state.

## Configuration
- Macro: `SYNC_FIFO_ERR_FLAGS_EN`.
- Defined:
  - `overflow` sets on `write_en && full && !read_en`.
  - `underflow` sets on `read_en && empty && !write_en`.
  - Both flags stay set until `rst`.
- Undefined: both ports remain present and are tied to 0. No error logic is generated.

## Structure
- Package `sync_fifo_pkg`: default `DATA_W`/`DEPTH` constants and the `ptr_t` and `cnt_t` typedef helpers.
- One sub-module, `sync_fifo_mem`:
  - DEPTH x DATA_W register array.
  - One write port, one asynchronous read port, no reset.
- Pointer, count, flag and bypass logic live in the top-level `sync_fifo`.

## Test plan
- Reset then idle: `count`=0, `empty`=1, `full`=0, `read_data`=0, flags 0.
- Write 0x1..0x8 on consecutive cycles:
  - `full`=1 with `count`=8.
  - Ninth write of 0x9 without read is dropped and sets `overflow`.
  - Reading 8 cycles returns 0x1..0x8 in order.
- Empty with `write_en`=`read_en`=1, `write_data`=0xDEADBEEF:
  - `read_data`=0xDEADBEEF in the same cycle.
  - `count` stays 0.
- Full with simultaneous read and write of 0xA5A5A5A5:
  - Head 0x1 is returned and `count` stays 8.
  - Eight further reads return 0x2..0x8, then 0xA5A5A5A5.
- 20 writes interleaved with reads at occupancy 3 (pointer wrap): output order matches input order, no loss.
- `rst` asserted with `count`=5 and a write pending:
  - Next cycle `count`=0, `empty`=1, flags cleared.
  - Subsequent read returns only newly written data.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default FIFO geometry plus pointer/occupancy type helpers
package sync_fifo_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 8;
  typedef logic [$clog2(DEF_DEPTH)-1:0] ptr_t;
  typedef logic [$clog2(DEF_DEPTH):0] cnt_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: unreset DEPTH x DATA_W register array; ports clk, we/waddr/wdata (write), raddr/rdata (async read)
module sync_fifo_mem import sync_fifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with empty bypass; ports clk/rst, write_en/write_data, read_en/read_data, full/empty/count, overflow/underflow (sticky, only when SYNC_FIFO_ERR_FLAGS_EN is defined, else tied 0)
module sync_fifo import sync_fifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] head;
  logic bypass, wr_acc, rd_acc, wr_mem, rd_mem;
  assign bypass = empty && write_en && read_en;
  assign wr_acc = write_en && (!full || read_en);
  assign rd_acc = read_en && (!empty || write_en);
  assign wr_mem = wr_acc && !bypass;
  assign rd_mem = rd_acc && !bypass;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign read_data = empty ? (write_en ? write_data : '0) : head;
  sync_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk(clk),
    .we(wr_mem),
    .waddr(wr_ptr),
    .wdata(write_data),
    .raddr(rd_ptr),
    .rdata(head)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_mem) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_mem) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr_mem) - CNT_W'(rd_mem);
    end
  end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && full && !read_en) overflow <= 1'b1;
      if (read_en && empty && !write_en) underflow <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed stimulus with a reference queue feeding an in-order scoreboard for sync_fifo
module tb_sync_fifo;
  import sync_fifo_pkg::*;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic write_en = 1'b0;
  logic [31:0] write_data = '0;
  logic read_en = 1'b0;
  logic [31:0] read_data;
  logic full, empty, overflow, underflow;
  cnt_t count;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mq[$];
  logic [31:0] sb[$];
  bit of_m = 1'b0;
  bit uf_m = 1'b0;
  sync_fifo dut (
    .clk(clk),
    .rst(rst),
    .write_en(write_en),
    .write_data(write_data),
    .read_en(read_en),
    .read_data(read_data),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_state(input string tag);
    chk({tag, " count"}, 64'(count), 64'(mq.size()));
    chk({tag, " empty"}, 64'(empty), 64'(mq.size() == 0));
    chk({tag, " full"}, 64'(full), 64'(mq.size() == 8));
    chk({tag, " overflow"}, 64'(overflow), 64'(ERR_EN && of_m));
    chk({tag, " underflow"}, 64'(underflow), 64'(ERR_EN && uf_m));
  endtask
  task automatic step(input bit we, input logic [31:0] wd, input bit re, input string tag);
    int sz;
    bit wacc, racc;
    sz = mq.size();
    write_en = we;
    write_data = wd;
    read_en = re;
    wacc = we && (sz < 8 || re);
    racc = re && (sz > 0 || we);
    if (racc) sb.push_back(sz > 0 ? mq[0] : wd);
    if (we && sz == 8 && !re) of_m = 1'b1;
    if (re && sz == 0 && !we) uf_m = 1'b1;
    if (!(sz == 0 && we && re)) begin
      if (racc) void'(mq.pop_front());
      if (wacc) mq.push_back(wd);
    end
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en = 1'b0;
    chk_state(tag);
  endtask
  always @(negedge clk) begin
    if (!rst && read_en) begin
      if (empty && !write_en) chk("empty read data", 64'(read_data), 64'h0);
      else if (sb.size() == 0) chk("unexpected read", 64'(read_data), 64'hx);
      else chk("read data", 64'(read_data), 64'(sb.pop_front()));
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset read_data", 64'(read_data), 64'h0);
    chk_state("reset");
    step(0, 0, 0, "idle");
    for (int i = 1; i <= 8; i++) step(1, 32'(i), 0, "fill");
    step(1, 32'h9, 0, "drop");
    for (int i = 0; i < 8; i++) step(0, 0, 1, "drain");
    step(0, 0, 1, "underrun");
    step(1, 32'hDEADBEEF, 1, "bypass");
    for (int i = 1; i <= 8; i++) step(1, 32'(i), 0, "refill");
    step(1, 32'hA5A5A5A5, 1, "full rw");
    for (int i = 0; i < 8; i++) step(0, 0, 1, "drain2");
    for (int i = 0; i < 3; i++) step(1, 32'h100 + 32'(i), 0, "wrap pre");
    for (int i = 3; i < 20; i++) step(1, 32'h100 + 32'(i), 1, "wrap");
    for (int i = 0; i < 3; i++) step(0, 0, 1, "wrap post");
    for (int i = 0; i < 5; i++) step(1, 32'h200 + 32'(i), 0, "pre rst");
    rst = 1'b1;
    write_en = 1'b1;
    write_data = 32'h2FF;
    mq.delete();
    of_m = 1'b0;
    uf_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    write_en = 1'b0;
    chk_state("mid rst");
    step(1, 32'h300, 0, "post rst wr");
    step(0, 0, 1, "post rst rd");
    @(negedge clk);
    chk("scoreboard leftover", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
